// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: op encodings,
// checker FSM states and the reference gate function.
package gate_chk_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_BUFX = 3'd6;
    localparam logic [2:0] OP_NOTX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } chk_state_e;

    // Expected output of the selected 2-input reference gate.
    function automatic logic gate_ref(input logic [2:0] op, input logic x, input logic y);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_BUFX: r = x;
            OP_NOTX: r = ~x;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gate_resp_checker.sv
// Gate response checker: waits for {x,y} to be stable for SETTLE_CYCLES
// cycles, compares z against the latched reference gate, counts checked
// vectors and mismatches and records the first failing vector.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [2:0]       op,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

    chk_state_e      state_q, state_d;
    logic [2:0]      op_q;
    logic [1:0]      last_xy;
    logic [SC_W-1:0] settle_cnt;

    logic [1:0] cur_xy;
    logic       xy_changed;
    logic       settle_done;
    logic       run_start;
    logic       in_check;
    logic       mismatch;
    logic       enter_done;
    logic       pass_next;

    assign cur_xy      = {x, y};
    assign xy_changed  = (cur_xy != last_xy);
    assign settle_done = (settle_cnt == SC_LAST);
    assign run_start   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_check    = (state_q == ST_CHECK);
    assign mismatch    = in_check && (z != gate_ref(op_q, last_xy[1], last_xy[0]));
    assign enter_done  = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Pass on entry from CHECK must reflect that same cycle's check; the
    // vector count is nonzero after that increment, so only errors matter.
    assign pass_next = in_check ? ((err_count == '0) && !mismatch)
                                : ((err_count == '0) && (vec_count != '0));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop has priority over input changes while busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (stop)             state_d = ST_DONE;
                else if (xy_changed)  state_d = ST_SETTLE;
                else if (settle_done) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = stop ? ST_DONE : ST_HOLD;
            end
            ST_HOLD: begin
                if (stop)            state_d = ST_DONE;
                else if (xy_changed) state_d = ST_SETTLE;
            end
            ST_DONE: begin
                if (start) state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SETTLE, ST_CHECK, ST_HOLD: busy = 1'b1;
            ST_DONE:                      done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Run context, settle tracking, first-fail capture and pass flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q             <= '0;
            last_xy          <= '0;
            settle_cnt       <= '0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (run_start) begin
            op_q             <= op;
            last_xy          <= cur_xy;
            settle_cnt       <= '0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (!stop) begin
                        if (xy_changed) begin
                            last_xy    <= cur_xy;
                            settle_cnt <= '0;
                        end else if (!settle_done) begin
                            settle_cnt <= settle_cnt + SC_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= {last_xy, z};
                        first_fail_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stop && xy_changed) begin
                        last_xy    <= cur_xy;
                        settle_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
            if (enter_done) begin
                pass <= pass_next;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (in_check),
        .count (vec_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (mismatch),
        .count (err_count)
    );

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Response-side companion to the gate stimulus benches. Watches the two inputs driven into a 2-input gate DUT and the DUT's output.
- Waits for the inputs to be stable, then compares the DUT output against a selectable reference gate function.
- Counts checked vectors and mismatches, and records the first failing vector.
- Lets gate benches self-check and lets the same check run on-chip beside the DUT, instead of reading monitor output by eye.

Parameters:
- SETTLE_CYCLES, 2, number of consecutive stable clock cycles on {x,y} before z is samped; must be >= 1.
- CNT_W, 8, width of vec_count and err_count; both saturate.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; latches op, clears results, begins a run.
- stop  input  1  one-cycle pulse; ends the run.
- op  input  3  reference function, latched at start: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 BUF(x), 7 NOT(x).
- x  input  1  DUT input A, synchronous to clk.
- y  input  1  DUT input B, synchronous to clk.
- z  input  1  DUT output, synchronous to clk.
- busy  output  1  high in SETTLE, CHECK and HOLD.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1: 1 iff err_count==0 and vec_count!=0.
- vec_count  output  CNT_W  vectors checked; saturates at all-ones.
- err_count  output  CNT_W  mismatches; saturates at all-ones.
- first_fail_valid  output  1  a mismatch has been recorded in this run.
- first_fail_vec  output  3  {x,y,z} of the first mismatching vector.

Behaviour:
- Reset (asynchronous, rst_n=0, any time including mid-run):
  - State goes to IDLE.
  - busy, done, pass, vec_count, err_count, first_fail_valid and first_fail_vec all go to 0.
  - The latched op, last_xy and settle_cnt go to 0.
- FSM states: IDLE, SETTLE, CHECK, HOLD, DONE.
- IDLE:
  - Outputs hold their current values.
  - start=1: latch op, last_xy<={x,y}, settle_cnt<=0, clear counters, first_fail_valid, first_fail_vec and pass, then go to SETTLE.
- SETTLE:
  - stop=1 has priority: go to DONE.
  - Else if {x,y}!=last_xy: last_xy<={x,y}, settle_cnt<=0, stay in SETTLE.
  - Else if settle_cnt==SETTLE_CYCLES-1: go to CHECK.
  - Else settle_cnt++.
- CHECK (exactly one cycle):
  - exp = f(op, last_xy).
  - vec_count++ (saturating).
  - If z!=exp: err_count++ (saturating). If first_fail_valid==0, set first_fail_vec<={last_xy,z} and first_fail_valid<=1.
  - Next state: DONE if stop=1 (the check still counts), else HOLD.
- HOLD:
  - stop=1 has priority: go to DONE.
  - Else if {x,y}!=last_xy: capture the new value, settle_cnt<=0, go to SETTLE.
  - Else stay. Each stable vector is checked once only; z changing while {x,y} is steady is ignored.
- DONE:
  - done=1; pass is computed on entry and then held.
  - start=1: restart exactly as from IDLE.
  - stop is ignored.
- start while busy: ignored. A run is only ended by stop or reset.
- Check latency: z is sampled SETTLE_CYCLES+1 rising edges after the edge on which a {x,y} change is first seen.
- Counter saturation: at all-ones, an increment leaves the value unchanged. No wrap.
- The block has no synchronizers; the DUT is in the clk domain.

Decomposition:
- Package gate_chk_pkg holds:
  - the op encoding constants (OP_AND..OP_NOTX),
  - the FSM state enum,
  - a function gate_ref(op, x, y) returning the expected output.
- One sub-module, sat_counter (CNT_W, inc, clr), used for both vec_count and err_count.

Test Plan (SETTLE_CYCLES=2, CNT_W=8 unless stated):
- Reset: pulse rst_n=0 while in SETTLE with vec_count=3 -> all outputs 0 in the same cycle, state IDLE; start is needed to run again.
- OR pass: op=1, z=x|y, vectors xy=00,10,11,10 each held 5 cycles, then stop -> done=1, pass=1, vec_count=4, err_count=0, first_fail_valid=0.
- OR stuck-at-0: op=1, z=0, vectors 00,01,11 then stop -> vec_count=3, err_count=2, first_fail_vec=3'b010, pass=0.
- Glitch filtering: xy=00 to 10, back to 00 after 1 cycle, then held -> one check only, at 3 edges after the return to 00; vec_count=1.
- Saturation with CNT_W=2: op=0, z=1, 5 distinct-change vectors -> err_count=3 and vec_count=3, held; pass=0.
- Empty run and restart: start then stop on the next cycle -> done=1, vec_count=0, pass=0; a second start in DONE -> busy=1, all counters cleared.
